// File: rtl/alu_operand_loader_if.sv
// Signal bundle between the switch bank / ALU side and the operand loader.
// The master side drives the switches, button, chain mode and ALU result; the slave side is the loader.
interface alu_operand_loader_if #(
    parameter int WIDTH    = 6,
    parameter int OP_WIDTH = 3
);
    logic [WIDTH-1:0] sw_data;
    logic             load_btn;
    logic             chain;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             f;
    logic             x;
    logic             n;
    logic             op_valid;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic [1:0]       stage;

    modport master (
        output sw_data, load_btn, chain, alu_result,
        input  input1, input2, f, x, n, op_valid, result, result_valid, stage
    );

    modport slave (
        input  sw_data, load_btn, chain, alu_result,
        output input1, input2, f, x, n, op_valid, result, result_valid, stage
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Operand/opcode sequencer for the 6-bit ALU: loads A, B and opcode one press at a time,
// runs one execute cycle, captures the result and optionally chains it back as the next A.
module alu_operand_loader #(
    parameter int WIDTH    = 6,
    parameter int OP_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_operand_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_EXEC = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic                btn_q;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [OP_WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                press;

    // Rising edge of the already-debounced button; btn_q resets high so a held button is not a press.
    assign press = bus.load_btn & ~btn_q;

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;

        case (state_q)
            S_A: begin
                if (press) begin
                    a_d            = bus.sw_data;
                    result_valid_d = 1'b0;
                    state_d        = S_B;
                end
            end
            S_B: begin
                // Clearing here matters only when S_B was entered by chaining.
                if (press) begin
                    b_d            = bus.sw_data;
                    result_valid_d = 1'b0;
                    state_d        = S_OP;
                end
            end
            S_OP: begin
                if (press) begin
                    op_d    = bus.sw_data[OP_WIDTH-1:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d       = bus.alu_result;
                result_valid_d = 1'b1;
                if (bus.chain) begin
                    a_d     = bus.alu_result;
                    state_d = S_B;
                end else begin
                    state_d = S_A;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_A;
            btn_q          <= 1'b1;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            btn_q          <= bus.load_btn;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // op_valid is a one-cycle strobe with no back-pressure: the ALU is combinational and
    // result/result_valid update on the edge that ends it; result_valid then holds until the next load.
    assign bus.input1       = a_q;
    assign bus.input2       = b_q;
    assign bus.f            = op_q[2];
    assign bus.x            = op_q[1];
    assign bus.n            = op_q[0];
    assign bus.op_valid     = (state_q == S_EXEC);
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.stage        = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: table of complete operations against a small ALU model,
// plus hand-written sequences for held buttons, reset mid-sequence and result_valid clearing.
module tb_alu_operand_loader;

    localparam int WIDTH    = 6;
    localparam int OP_WIDTH = 3;

    logic clk;
    logic reset;

    int checks;
    int errors;

    logic [WIDTH-1:0] exp_q[$];

    alu_operand_loader_if #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) bus ();

    alu_operand_loader #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in for the downstream ALU: 110 add, 111 subtract, 100 unsigned less-than.
    function automatic logic [WIDTH-1:0] alu_model(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [2:0] op);
        case (op)
            3'b110:  return a + b;
            3'b111:  return a - b;
            3'b100:  return (a < b) ? 6'd1 : 6'd0;
            default: return a & b;
        endcase
    endfunction

    always_comb bus.alu_result = alu_model(bus.input1, bus.input2, {bus.f, bus.x, bus.n});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Raise the button for one edge; leaves it low so the caller can check and then release-tick.
    task automatic press_edge(input logic [WIDTH-1:0] val);
        bus.sw_data  = val;
        bus.load_btn = 1'b1;
        tick();
        bus.load_btn = 1'b0;
    endtask

    typedef struct {
        bit               skip_a;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] op_sw;
        bit               chain;
        logic [WIDTH-1:0] exp_in1;
        logic [WIDTH-1:0] exp_in2;
        logic [2:0]       exp_op;
        logic [WIDTH-1:0] exp_result;
        logic [1:0]       exp_stage;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [WIDTH-1:0] exp_r;
        checks = 0;
        errors = 0;

        //                skip a        b        op_sw       ch in1      in2      op      result   stage
        vecs[0] = '{1'b0, 6'd7,  6'd3, 6'b000111, 1'b0, 6'd7,  6'd3, 3'b111, 6'd4,  2'b00};
        vecs[1] = '{1'b0, 6'd3,  6'd6, 6'b111100, 1'b0, 6'd3,  6'd6, 3'b100, 6'd1,  2'b00};
        vecs[2] = '{1'b0, 6'd6,  6'd3, 6'b000100, 1'b0, 6'd6,  6'd3, 3'b100, 6'd0,  2'b00};
        vecs[3] = '{1'b0, 6'd1,  6'd1, 6'b000110, 1'b1, 6'd1,  6'd1, 3'b110, 6'd2,  2'b01};
        vecs[4] = '{1'b1, 6'd0,  6'd3, 6'b000111, 1'b0, 6'd2,  6'd3, 3'b111, 6'd63, 2'b00};
        vecs[5] = '{1'b0, 6'd63, 6'd1, 6'b000110, 1'b0, 6'd63, 6'd1, 3'b110, 6'd0,  2'b00};
        vecs[6] = '{1'b0, 6'd5,  6'd2, 6'b101110, 1'b1, 6'd5,  6'd2, 3'b110, 6'd7,  2'b01};
        vecs[7] = '{1'b1, 6'd0,  6'd2, 6'b000111, 1'b1, 6'd7,  6'd2, 3'b111, 6'd5,  2'b01};
        vecs[8] = '{1'b1, 6'd0,  6'd6, 6'b010100, 1'b0, 6'd5,  6'd6, 3'b100, 6'd1,  2'b00};

        reset        = 1'b1;
        bus.sw_data  = '0;
        bus.load_btn = 1'b0;
        bus.chain    = 1'b0;
        repeat (3) tick();
        check("reset_stage", 32'(bus.stage), 32'(2'b00));
        check("reset_input1", 32'(bus.input1), 32'(6'd0));
        check("reset_input2", 32'(bus.input2), 32'(6'd0));
        check("reset_op", 32'({bus.f, bus.x, bus.n}), 32'(3'b000));
        check("reset_result", 32'(bus.result), 32'(6'd0));
        check("reset_result_valid", 32'(bus.result_valid), 32'(1'b0));
        check("reset_op_valid", 32'(bus.op_valid), 32'(1'b0));
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            if (!vecs[i].skip_a) begin
                press_edge(vecs[i].a);
                check("a_load_stage", 32'(bus.stage), 32'(2'b01));
                check("a_load_input1", 32'(bus.input1), 32'(vecs[i].exp_in1));
                check("a_load_result_valid", 32'(bus.result_valid), 32'(1'b0));
                tick();
            end else begin
                check("chain_stage", 32'(bus.stage), 32'(2'b01));
                check("chain_input1", 32'(bus.input1), 32'(vecs[i].exp_in1));
                check("chain_result_valid_held", 32'(bus.result_valid), 32'(1'b1));
            end
            press_edge(vecs[i].b);
            check("b_load_stage", 32'(bus.stage), 32'(2'b10));
            check("b_load_result_valid", 32'(bus.result_valid), 32'(1'b0));
            check("b_load_op_valid", 32'(bus.op_valid), 32'(1'b0));
            tick();
            bus.chain = vecs[i].chain;
            press_edge(vecs[i].op_sw);
            exp_q.push_back(vecs[i].exp_result);
            check("exec_stage", 32'(bus.stage), 32'(2'b11));
            check("exec_op_valid", 32'(bus.op_valid), 32'(1'b1));
            check("exec_input1", 32'(bus.input1), 32'(vecs[i].exp_in1));
            check("exec_input2", 32'(bus.input2), 32'(vecs[i].exp_in2));
            check("exec_op", 32'({bus.f, bus.x, bus.n}), 32'(vecs[i].exp_op));
            tick();
            bus.chain = 1'b0;
            exp_r = exp_q.pop_front();
            check("done_result", 32'(bus.result), 32'(exp_r));
            check("done_result_valid", 32'(bus.result_valid), 32'(1'b1));
            check("done_op_valid", 32'(bus.op_valid), 32'(1'b0));
            check("done_stage", 32'(bus.stage), 32'(vecs[i].exp_stage));
        end

        // Button held for 50 cycles in S_A loads exactly once.
        bus.sw_data  = 6'd9;
        bus.load_btn = 1'b1;
        repeat (50) tick();
        check("held_stage", 32'(bus.stage), 32'(2'b01));
        check("held_input1", 32'(bus.input1), 32'(6'd9));
        check("held_input2_untouched", 32'(bus.input2), 32'(6'd6));
        bus.load_btn = 1'b0;
        tick();
        check("held_release_stage", 32'(bus.stage), 32'(2'b01));

        // Reset coinciding with a press wins, and a button held across reset release gives no press.
        bus.sw_data  = 6'd17;
        bus.load_btn = 1'b1;
        reset        = 1'b1;
        tick();
        check("midreset_stage", 32'(bus.stage), 32'(2'b00));
        check("midreset_input1", 32'(bus.input1), 32'(6'd0));
        check("midreset_input2", 32'(bus.input2), 32'(6'd0));
        check("midreset_result", 32'(bus.result), 32'(6'd0));
        check("midreset_result_valid", 32'(bus.result_valid), 32'(1'b0));
        reset = 1'b0;
        repeat (5) tick();
        check("held_reset_stage", 32'(bus.stage), 32'(2'b00));
        check("held_reset_input1", 32'(bus.input1), 32'(6'd0));
        bus.load_btn = 1'b0;
        tick();
        press_edge(6'd17);
        check("repress_stage", 32'(bus.stage), 32'(2'b01));
        check("repress_input1", 32'(bus.input1), 32'(6'd17));
        tick();

        // Complete an op, then a new A press drops result_valid but keeps result.
        press_edge(6'd4);
        tick();
        press_edge(6'b000110);
        tick();
        check("post_op_result", 32'(bus.result), 32'(6'd21));
        check("post_op_result_valid", 32'(bus.result_valid), 32'(1'b1));
        check("post_op_stage", 32'(bus.stage), 32'(2'b00));
        press_edge(6'd2);
        check("newa_result_valid", 32'(bus.result_valid), 32'(1'b0));
        check("newa_result_kept", 32'(bus.result), 32'(6'd21));
        check("newa_stage", 32'(bus.stage), 32'(2'b01));
        check("newa_input1", 32'(bus.input1), 32'(6'd2));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
